scmp_bus_ctl: RTL and testbench

SCMP_BUS_CTL -- requirements
Module: scmp_bus_ctl

---
 rtl/scmp_bus_ctl.sv | 189 ++++++++++++++++++
 tb/tb_scmp_bus_ctl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/scmp_bus_ctl.sv
// SC/MP external bus cycle controller: daisy-chain arbitration, address strobe,
// stretched RD_n/WR_n strobe with HOLD_n wait states. Optional abort: SCMP_BUS_TIMEOUT_EN.
module scmp_bus_ctl #(
  parameter int unsigned STROBE_MIN = 2,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_rd,
  input  logic        req_wr,
  input  logic [3:0]  req_flags,
  input  logic [15:0] addr_in,
  input  logic [7:0]  wdata,
  output logic        stall,
  output logic        done,
  output logic [7:0]  rdata,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_dout,
  input  logic [7:0]  bus_din,
  output logic [3:0]  bus_flags,
  output logic        bus_ADS_n,
  output logic        bus_RD_n,
  output logic        bus_WR_n,
  output logic        bus_BREQ,
  input  logic        bus_ENIN,
  output logic        bus_ENOUT,
  input  logic        bus_HOLD_n,
  output logic        timeout
);

  if (STROBE_MIN < 1 || STROBE_MIN > 15) begin : g_bad_strobe_min
    $error("STROBE_MIN out of range 1-15");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("TIMEOUT out of range 1-255");
  end

  localparam logic [3:0] SMIN = 4'(STROBE_MIN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_ADDR,
    S_STROBE,
    S_DONE
  } state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [7:0]  rdata_q;
  logic [15:0] addr_q;
  logic [7:0]  dout_q;
  logic [3:0]  flags_q;
  logic        is_rd_q;
  logic        done_q;
  logic        breq_q;
  logic        ads_n_q;
  logic        rd_n_q;
  logic        wr_n_q;
  logic        req_any;

`ifdef SCMP_BUS_TIMEOUT_EN
  localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);
  logic [7:0] tcnt_q;
  logic       tmo_q;
`endif

  assign req_any = req_rd | req_wr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      addr_q  <= '0;
      dout_q  <= '0;
      flags_q <= '0;
      is_rd_q <= 1'b0;
      done_q  <= 1'b0;
      breq_q  <= 1'b0;
      ads_n_q <= 1'b1;
      rd_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
`ifdef SCMP_BUS_TIMEOUT_EN
      tcnt_q  <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef SCMP_BUS_TIMEOUT_EN
      tmo_q  <= 1'b0;
`endif
      unique case (state_q)
        S_IDLE: begin
          if (req_any) begin
            addr_q  <= addr_in;
            dout_q  <= wdata;
            flags_q <= req_flags;
            is_rd_q <= req_rd;  // read wins when both are requested
            breq_q  <= 1'b1;
            state_q <= S_ARB;
`ifdef SCMP_BUS_TIMEOUT_EN
            tcnt_q  <= '0;
`endif
          end
        end
        S_ARB: begin
          if (bus_ENIN) begin
            ads_n_q <= 1'b0;
            state_q <= S_ADDR;
          end
`ifdef SCMP_BUS_TIMEOUT_EN
          else if (tcnt_q == TLAST) begin
            breq_q  <= 1'b0;
            done_q  <= 1'b1;
            tmo_q   <= 1'b1;
            if (is_rd_q) rdata_q <= 8'hFF;
            state_q <= S_DONE;
          end else begin
            tcnt_q <= tcnt_q + 8'd1;
          end
`endif
        end
        S_ADDR: begin
          ads_n_q <= 1'b1;
          rd_n_q  <= ~is_rd_q;
          wr_n_q  <= is_rd_q;
          cnt_q   <= 4'd1;
          state_q <= S_STROBE;
`ifdef SCMP_BUS_TIMEOUT_EN
          tcnt_q  <= '0;
`endif
        end
        S_STROBE: begin
          // cnt_q counts strobe-low cycles including the current one
          if (cnt_q < SMIN) begin
            cnt_q <= cnt_q + 4'd1;
          end else if (bus_HOLD_n) begin
            rd_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
            breq_q  <= 1'b0;
            done_q  <= 1'b1;
            cnt_q   <= '0;
            if (is_rd_q) rdata_q <= bus_din;
            state_q <= S_DONE;
          end
`ifdef SCMP_BUS_TIMEOUT_EN
          else if (tcnt_q == TLAST) begin
            rd_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
            breq_q  <= 1'b0;
            done_q  <= 1'b1;
            tmo_q   <= 1'b1;
            cnt_q   <= '0;
            if (is_rd_q) rdata_q <= 8'hFF;
            state_q <= S_DONE;
          end else begin
            tcnt_q <= tcnt_q + 8'd1;
          end
`endif
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign stall     = req_any & ~done_q;
  assign bus_ENOUT = bus_ENIN & (state_q == S_IDLE) & ~req_any;
  assign done      = done_q;
  assign rdata     = rdata_q;
  assign bus_addr  = addr_q;
  assign bus_dout  = dout_q;
  assign bus_flags = flags_q;
  assign bus_ADS_n = ads_n_q;
  assign bus_RD_n  = rd_n_q;
  assign bus_WR_n  = wr_n_q;
  assign bus_BREQ  = breq_q;
`ifdef SCMP_BUS_TIMEOUT_EN
  assign timeout   = tmo_q;
`else
  assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_scmp_bus_ctl.sv
// Bench for scmp_bus_ctl: per-transaction event timeline derived from the bus
// rules (arbitration wait, strobe minimum, HOLD_n extension, optional abort).
module tb_scmp_bus_ctl;

  localparam int SMIN = 2;
  localparam int NCYC = 64;
`ifdef SCMP_BUS_TIMEOUT_EN
  localparam int TMO_LIM = 8;
`else
  localparam int TMO_LIM = 100000;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_rd, req_wr;
  logic [3:0]  req_flags;
  logic [15:0] addr_in;
  logic [7:0]  wdata;
  logic        stall, done, timeout;
  logic [7:0]  rdata;
  logic [15:0] bus_addr;
  logic [7:0]  bus_dout, bus_din;
  logic [3:0]  bus_flags;
  logic        bus_ADS_n, bus_RD_n, bus_WR_n, bus_BREQ, bus_ENIN, bus_ENOUT, bus_HOLD_n;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [7:0]  rdata_exp = 8'h00;

  logic        enin_a [NCYC];
  logic        hold_a [NCYC];
  logic [7:0]  din_a  [NCYC];

  scmp_bus_ctl #(.STROBE_MIN(SMIN), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_rd(req_rd), .req_wr(req_wr),
    .req_flags(req_flags), .addr_in(addr_in), .wdata(wdata),
    .stall(stall), .done(done), .rdata(rdata),
    .bus_addr(bus_addr), .bus_dout(bus_dout), .bus_din(bus_din),
    .bus_flags(bus_flags), .bus_ADS_n(bus_ADS_n), .bus_RD_n(bus_RD_n),
    .bus_WR_n(bus_WR_n), .bus_BREQ(bus_BREQ), .bus_ENIN(bus_ENIN),
    .bus_ENOUT(bus_ENOUT), .bus_HOLD_n(bus_HOLD_n), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic fill_const(input logic en, input logic hd, input logic [7:0] d);
    for (int t = 0; t < NCYC; t++) begin
      enin_a[t] = en; hold_a[t] = hd; din_a[t] = d;
    end
  endtask

  task automatic fill_random();
    for (int t = 0; t < NCYC; t++) begin
      enin_a[t] = (($urandom % 3) != 0) || (t >= 30);
      hold_a[t] = (($urandom % 4) != 0) || (t >= 30);
      din_a[t]  = 8'($urandom);
    end
  endtask

  // One bus transaction starting in IDLE at cycle 0. drop_at: first cycle with
  // the request removed; rst_at: cycle during which rst_n is held low (-1 none).
  task automatic run_txn(input string name, input logic do_rd, input logic do_wr,
                         input logic [15:0] a, input logic [7:0] wd, input logic [3:0] fl,
                         input int drop_at, input int rst_at);
    int addr_c = -1, ss = -1, se = -1, done_c = NCYC - 2, last_t, w;
    bit abort = 0;
    logic is_rd = do_rd;
    logic [7:0] new_rd;
    logic [7:0] got, exp;
    w = 0;
    for (int t = 1; t < NCYC - 2; t++) begin
      if (enin_a[t]) begin addr_c = t + 1; break; end
      w++;
      if (w == TMO_LIM) begin done_c = t + 1; abort = 1; break; end
    end
    if (addr_c > 0) begin
      ss = addr_c + 1;
      w = 0;
      for (int t = ss + SMIN - 1; t < NCYC - 2; t++) begin
        if (hold_a[t]) begin se = t; break; end
        w++;
        if (w == TMO_LIM) begin se = t; abort = 1; break; end
      end
      if (se > 0) done_c = se + 1;
    end
    new_rd = !is_rd ? rdata_exp : (abort ? 8'hFF : din_a[se < 0 ? 0 : se]);
    last_t = (rst_at >= 0) ? rst_at + 2 : done_c + 1;

    for (int t = 0; t <= last_t; t++) begin
      bit alive, req, brk, stb, dn;
      @(posedge clk); #1;
      alive      = (rst_at < 0) || (t <= rst_at);
      req        = alive && (t < drop_at) && (t <= done_c);
      rst_n      = !(t == rst_at);
      req_rd     = do_rd & req;
      req_wr     = do_wr & req;
      addr_in    = (t == 0) ? a  : 16'($urandom);
      wdata      = (t == 0) ? wd : 8'($urandom);
      req_flags  = (t == 0) ? fl : 4'($urandom);
      bus_ENIN   = enin_a[t];
      bus_HOLD_n = hold_a[t];
      bus_din    = din_a[t];
      @(negedge clk);
      alive = (rst_at < 0) || (t <= rst_at);
      brk = alive && t >= 1 && t < done_c;
      stb = alive && ss > 0 && t >= ss && t <= se;
      dn  = alive && t == done_c;
      exp = {brk, !(alive && t == addr_c), !(stb && is_rd), !(stb && !is_rd),
             dn, dn && abort, req && !dn,
             bus_ENIN && !req && (t == 0 || t > done_c || !alive)};
      got = {bus_BREQ, bus_ADS_n, bus_RD_n, bus_WR_n, done, timeout, stall, bus_ENOUT};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL %s t=%0d ctl {BREQ,ADS,RD,WR,done,tmo,stall,ENOUT} got=%b exp=%b",
                 name, t, got, exp);
      end
      if (alive && t >= 1 && t < done_c) begin
        n_tests++;
        if ({bus_addr, bus_flags, bus_dout} !== {a, fl, wd}) begin
          n_fail++;
          $display("FAIL %s t=%0d bus addr/flags/dout got=%h/%h/%h exp=%h/%h/%h",
                   name, t, bus_addr, bus_flags, bus_dout, a, fl, wd);
        end
      end
      if (!alive && t == rst_at + 1) begin
        rdata_exp = 8'h00;
        n_tests++;
        if ({bus_addr, bus_flags, bus_dout, rdata} !== 36'h0) begin
          n_fail++;
          $display("FAIL %s t=%0d reset latches got=%h/%h/%h/%h exp=0",
                   name, t, bus_addr, bus_flags, bus_dout, rdata);
        end
      end
      if (alive && t == done_c) begin
        rdata_exp = new_rd;
        n_tests++;
        if (rdata !== rdata_exp) begin
          n_fail++;
          $display("FAIL %s t=%0d rdata got=%h exp=%h", name, t, rdata, rdata_exp);
        end
      end
    end
  endtask

  task automatic idle_cycles(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      req_rd = 1'b0; req_wr = 1'b0; rst_n = 1'b1;
      bus_ENIN = 1'($urandom); bus_HOLD_n = 1'b1;
      @(negedge clk);
      n_tests++;
      if ({bus_BREQ, bus_ADS_n, bus_RD_n, bus_WR_n, done, timeout, stall, bus_ENOUT}
          !== {5'b01110, 2'b00, bus_ENIN} || rdata !== rdata_exp) begin
        n_fail++;
        $display("FAIL %s idle %0d got=%b rdata=%h exp=0111000%b rdata=%h", name, i,
                 {bus_BREQ, bus_ADS_n, bus_RD_n, bus_WR_n, done, timeout, stall, bus_ENOUT},
                 rdata, bus_ENIN, rdata_exp);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_rd = 1'b1; req_wr = 1'b0; bus_ENIN = 1'b1; bus_HOLD_n = 1'b1;
    addr_in = 16'hBEEF; wdata = 8'h77; req_flags = 4'hF; bus_din = 8'h55;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({bus_BREQ, bus_ADS_n, bus_RD_n, bus_WR_n, done, timeout, stall, bus_ENOUT} !== 8'b01110010
        || {bus_addr, bus_flags, bus_dout, rdata} !== 36'h0) begin
      n_fail++;
      $display("FAIL reset got ctl=%b addr=%h fl=%h dout=%h rdata=%h exp ctl=01110010 rest 0",
               {bus_BREQ, bus_ADS_n, bus_RD_n, bus_WR_n, done, timeout, stall, bus_ENOUT},
               bus_addr, bus_flags, bus_dout, rdata);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; req_rd = 1'b0;
    idle_cycles("reset_idle", 2);
  endtask

  task automatic test_read_basic();
    fill_const(1'b1, 1'b1, 8'hA5);
    run_txn("read_basic", 1'b1, 1'b0, 16'h1234, 8'h00, 4'b0000, NCYC, -1);
  endtask

  task automatic test_write_basic();
    fill_const(1'b1, 1'b1, 8'h11);
    run_txn("write_basic", 1'b0, 1'b1, 16'h0F00, 8'h3C, 4'b0001, NCYC, -1);
  endtask

  task automatic test_both_req();
    fill_const(1'b1, 1'b1, 8'h6B);
    run_txn("both_req", 1'b1, 1'b1, 16'hABCD, 8'h99, 4'b1010, NCYC, -1);
  endtask

  task automatic test_arb_wait();
    fill_const(1'b1, 1'b1, 8'h42);
    for (int t = 1; t <= 10; t++) enin_a[t] = 1'b0;
    for (int t = 12; t < 16; t++) enin_a[t] = 1'b0;  // ENIN loss after grant is ignored
    run_txn("arb_wait", 1'b1, 1'b0, 16'h5A5A, 8'h00, 4'b0100, NCYC, -1);
  endtask

  task automatic test_hold();
    fill_const(1'b1, 1'b1, 8'hC3);
    for (int t = 4; t <= 7; t++) hold_a[t] = 1'b0;
    run_txn("hold_ext", 1'b1, 1'b0, 16'h8001, 8'h00, 4'b0010, NCYC, -1);
  endtask

  task automatic test_drop_req();
    fill_const(1'b1, 1'b1, 8'h3E);
    run_txn("drop_req", 1'b1, 1'b0, 16'h0042, 8'h00, 4'b1000, 2, -1);
    idle_cycles("drop_req_after", 4);
  endtask

  task automatic test_reset_mid();
    fill_const(1'b1, 1'b1, 8'hE7);
    run_txn("reset_mid", 1'b1, 1'b0, 16'h7777, 8'h00, 4'b0110, NCYC, 3);
    idle_cycles("reset_mid_after", 3);
    fill_const(1'b1, 1'b1, 8'h5C);
    run_txn("reset_mid_restart", 1'b1, 1'b0, 16'h2468, 8'h00, 4'b0011, NCYC, -1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      logic r, wv;
      fill_random();
      r  = 1'($urandom);
      wv = !r || (($urandom % 4) == 0);
      run_txn("random", r, wv, 16'($urandom), 8'($urandom), 4'($urandom),
              (($urandom % 5) == 0) ? 1 + int'($urandom % 4) : NCYC, -1);
    end
  endtask

`ifdef SCMP_BUS_TIMEOUT_EN
  task automatic test_timeout();
    fill_const(1'b0, 1'b1, 8'h12);
    enin_a[0] = 1'b1;
    run_txn("timeout_arb", 1'b1, 1'b0, 16'hDEAD, 8'h00, 4'b0001, NCYC, -1);
    fill_const(1'b1, 1'b0, 8'h34);
    run_txn("timeout_hold", 1'b1, 1'b0, 16'hBEAD, 8'h00, 4'b0001, NCYC, -1);
  endtask
`endif

  initial begin
    test_reset();
    test_read_basic();
    test_write_basic();
    test_both_req();
    test_arb_wait();
    test_hold();
    test_drop_req();
    test_reset_mid();
`ifdef SCMP_BUS_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    idle_cycles("final", 2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
